// File: rtl/notch_level_monitor_pkg.sv
// Shared definitions for the notch level monitor.
//   SAMPLE_W   : width of notch filter samples and of the mean/peak levels
//   state_t    : alarm FSM states
//   abs_sample : magnitude of a signed sample as an unsigned value
package notch_level_monitor_pkg;

    localparam int SAMPLE_W = 14;

    typedef enum logic [1:0] {
        ST_QUIET     = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ALARM     = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    // The most negative input maps onto 2^(SAMPLE_W-1), which still fits
    // once the result is read as unsigned.
    function automatic logic [SAMPLE_W-1:0] abs_sample(input logic [SAMPLE_W-1:0] y);
        return y[SAMPLE_W-1] ? (~y + SAMPLE_W'(1)) : y;
    endfunction

endpackage

// File: rtl/notch_level_monitor_if.sv
// Bus between a sample source / level consumer and the notch level monitor.
//   y_in, in_valid : sample stream (signed). No back-pressure: every cycle
//                    with in_valid high is one sample, consumed that cycle.
//   clr            : synchronous restart of window and alarm FSM
//   mean_out       : mean |y| of last completed window
//   peak_out       : max |y| of last completed window
//   win_valid      : one-cycle pulse when mean_out/peak_out update
//   alarm          : registered alarm flag
//   fsm_state      : current alarm FSM state (observation only)
interface notch_level_monitor_if;
    import notch_level_monitor_pkg::*;

    logic signed [SAMPLE_W-1:0] y_in;
    logic                       in_valid;
    logic                       clr;
    logic        [SAMPLE_W-1:0] mean_out;
    logic        [SAMPLE_W-1:0] peak_out;
    logic                       win_valid;
    logic                       alarm;
    state_t                     fsm_state;

    modport master (
        output y_in, in_valid, clr,
        input  mean_out, peak_out, win_valid, alarm, fsm_state
    );

    modport slave (
        input  y_in, in_valid, clr,
        output mean_out, peak_out, win_valid, alarm, fsm_state
    );

endinterface

// File: rtl/notch_level_monitor_level_window_acc.sv
// Windowed level measurement: |y| register stage, then accumulate / max /
// count over 2^WIN_LOG2 valid samples.
//   clk, rst_n  : clock, async active-low reset
//   y_i,valid_i : signed sample and its qualifier
//   clr_i       : synchronous restart of the partial window
//   mean_o      : truncated mean |y| of last completed window
//   peak_o      : max |y| of last completed window
//   win_valid_o : pulse in the cycle after mean_o/peak_o load
module level_window_acc
    import notch_level_monitor_pkg::*;
#(
    parameter int WIN_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] y_i,
    input  logic                valid_i,
    input  logic                clr_i,
    output logic [SAMPLE_W-1:0] mean_o,
    output logic [SAMPLE_W-1:0] peak_o,
    output logic                win_valid_o
);

    // Wide enough for 2^WIN_LOG2 samples of 2^(SAMPLE_W-1): cannot overflow.
    localparam int ACC_W = WIN_LOG2 + SAMPLE_W;

    logic [SAMPLE_W-1:0] abs_q;
    logic                vld_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [SAMPLE_W-1:0] max_q, max_d;
    logic [WIN_LOG2-1:0] cnt_q;
    logic [SAMPLE_W-1:0] mean_q, peak_q;
    logic                win_valid_q;
    logic                wrap;

    // acc_d/max_d include the sample sitting in stage 1 this cycle.
    assign acc_d = acc_q + ACC_W'(abs_q);
    assign max_d = (abs_q > max_q) ? abs_q : max_q;
    assign wrap  = vld_q && (cnt_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_q       <= '0;
            vld_q       <= 1'b0;
            acc_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            mean_q      <= '0;
            peak_q      <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            if (clr_i) begin
                // Drops both the incoming sample and the one in stage 1.
                abs_q <= '0;
                vld_q <= 1'b0;
                acc_q <= '0;
                max_q <= '0;
                cnt_q <= '0;
            end else begin
                abs_q <= abs_sample(y_i);
                vld_q <= valid_i;
                if (vld_q) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (wrap) begin
                        mean_q      <= SAMPLE_W'(acc_d >> WIN_LOG2);
                        peak_q      <= max_d;
                        acc_q       <= '0;
                        max_q       <= '0;
                        win_valid_q <= 1'b1;
                    end else begin
                        acc_q <= acc_d;
                        max_q <= max_d;
                    end
                end
            end
        end
    end

    assign mean_o      = mean_q;
    assign peak_o      = peak_q;
    assign win_valid_o = win_valid_q;

endmodule

// File: rtl/notch_level_monitor.sv
// Notch filter output level monitor: measures mean and peak |y| per window
// and raises an alarm with hysteresis (THR_ON / THR_OFF) and a debounce of
// HOLD_WIN consecutive qualifying windows in each direction.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of notch_level_monitor_if (samples in, levels,
//                window pulse, alarm and FSM state out)
module notch_level_monitor
    import notch_level_monitor_pkg::*;
#(
    parameter int WIN_LOG2 = 10,
    parameter int THR_ON   = 2000,
    parameter int THR_OFF  = 1000,
    parameter int HOLD_WIN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    notch_level_monitor_if.slave  bus
);

    localparam logic [SAMPLE_W-1:0] THR_ON_L  = SAMPLE_W'(THR_ON);
    localparam logic [SAMPLE_W-1:0] THR_OFF_L = SAMPLE_W'(THR_OFF);
    localparam logic [3:0]          HOLD_L    = 4'(HOLD_WIN);
    localparam bit                  HOLD_ONE  = (HOLD_WIN == 1);

    logic [SAMPLE_W-1:0] mean_w, peak_w;
    logic                win_valid_w;
    logic                loud, quiet;

    state_t     state_q;
    logic [3:0] hold_q;
    logic       alarm_q;

    level_window_acc #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .y_i         (bus.y_in),
        .valid_i     (bus.in_valid),
        .clr_i       (bus.clr),
        .mean_o      (mean_w),
        .peak_o      (peak_w),
        .win_valid_o (win_valid_w)
    );

    // mean_w is already the new window's value during the win_valid cycle.
    assign loud  = (mean_w >= THR_ON_L);
    assign quiet = (mean_w <  THR_OFF_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_QUIET;
            hold_q  <= '0;
            alarm_q <= 1'b0;
        end else if (bus.clr) begin
            state_q <= ST_QUIET;
            hold_q  <= '0;
            alarm_q <= 1'b0;
        end else if (win_valid_w) begin
            case (state_q)
                ST_QUIET: begin
                    if (loud) begin
                        if (HOLD_ONE) begin
                            state_q <= ST_ALARM;
                            hold_q  <= '0;
                            alarm_q <= 1'b1;
                        end else begin
                            state_q <= ST_ARMING;
                            hold_q  <= 4'd1;
                        end
                    end
                end
                ST_ARMING: begin
                    if (loud) begin
                        if (hold_q + 4'd1 == HOLD_L) begin
                            state_q <= ST_ALARM;
                            hold_q  <= '0;
                            alarm_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 4'd1;
                        end
                    end else begin
                        state_q <= ST_QUIET;
                        hold_q  <= '0;
                    end
                end
                ST_ALARM: begin
                    if (quiet) begin
                        if (HOLD_ONE) begin
                            state_q <= ST_QUIET;
                            hold_q  <= '0;
                            alarm_q <= 1'b0;
                        end else begin
                            state_q <= ST_RELEASING;
                            hold_q  <= 4'd1;
                        end
                    end
                end
                ST_RELEASING: begin
                    if (quiet) begin
                        if (hold_q + 4'd1 == HOLD_L) begin
                            state_q <= ST_QUIET;
                            hold_q  <= '0;
                            alarm_q <= 1'b0;
                        end else begin
                            hold_q <= hold_q + 4'd1;
                        end
                    end else begin
                        state_q <= ST_ALARM;
                        hold_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_QUIET;
                    hold_q  <= '0;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mean_out  = mean_w;
    assign bus.peak_out  = peak_w;
    assign bus.win_valid = win_valid_w;
    assign bus.alarm     = alarm_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_notch_level_monitor.sv
// Directed bench for notch_level_monitor with 16-sample windows.
module tb_notch_level_monitor;
    import notch_level_monitor_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    notch_level_monitor_if bus ();

    notch_level_monitor #(
        .WIN_LOG2 (4),
        .THR_ON   (2000),
        .THR_OFF  (1000),
        .HOLD_WIN (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- drivers ----------------
    // Inputs change on the falling edge; outputs read at a falling edge
    // reflect the preceding rising edge.
    task automatic step(input logic signed [13:0] y, input logic v);
        @(negedge clk);
        bus.y_in     = y;
        bus.in_valid = v;
    endtask

    task automatic feed(input logic signed [13:0] a, input logic signed [13:0] b,
                        input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) step(14'sd1234, 1'b0);
            step((i % 2 == 0) ? a : b, 1'b1);
        end
    endtask

    // Three idle cycles after the last sample: observations after the
    // capture edge, after the load edge and after the FSM edge.
    task automatic close_window(output logic wv0, output logic wv1, output logic wv2,
                                output logic [13:0] mean, output logic [13:0] peak,
                                output logic alarm_at_wv, output logic alarm_after,
                                output state_t st_after);
        step(14'sd0, 1'b0);
        wv0 = bus.win_valid;
        step(14'sd0, 1'b0);
        wv1         = bus.win_valid;
        mean        = bus.mean_out;
        peak        = bus.peak_out;
        alarm_at_wv = bus.alarm;
        step(14'sd0, 1'b0);
        wv2         = bus.win_valid;
        alarm_after = bus.alarm;
        st_after    = bus.fsm_state;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        bus.y_in     = '0;
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mean_out !== 14'd0 || bus.peak_out !== 14'd0 || bus.win_valid !== 1'b0 ||
            bus.alarm !== 1'b0 || bus.fsm_state !== ST_QUIET) begin
            errors++;
            $display("FAIL reset: mean=%0d peak=%0d wv=%b alarm=%b st=%0d, required all zero/QUIET",
                     bus.mean_out, bus.peak_out, bus.win_valid, bus.alarm, bus.fsm_state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_windows();
        logic w0, w1, w2, a0, a1;
        logic [13:0] m, p;
        state_t s;
        // +100 constant: also checks the 2-cycle latency.
        feed(14'sd100, 14'sd100, 1'b0);
        close_window(w0, w1, w2, m, p, a0, a1, s);
        checks++;
        if ({w0, w1, w2} !== 3'b010) begin
            errors++;
            $display("FAIL latency_100: wv seq=%b%b%b, required 010", w0, w1, w2);
        end
        checks++;
        if (m !== 14'd100 || p !== 14'd100) begin
            errors++;
            $display("FAIL level_100: mean=%0d peak=%0d, required 100/100", m, p);
        end
        // Most negative sample.
        feed(-14'sd8192, -14'sd8192, 1'b0);
        close_window(w0, w1, w2, m, p, a0, a1, s);
        checks++;
        if (w1 !== 1'b1 || m !== 14'd8192 || p !== 14'd8192) begin
            errors++;
            $display("FAIL level_neg8192: wv=%b mean=%0d peak=%0d, required 1/8192/8192", w1, m, p);
        end
        // +50/-150 alternating: (8*50 + 8*150)/16 = 100, peak 150.
        feed(14'sd50, -14'sd150, 1'b0);
        close_window(w0, w1, w2, m, p, a0, a1, s);
        checks++;
        if (w1 !== 1'b1 || m !== 14'd100 || p !== 14'd150) begin
            errors++;
            $display("FAIL level_alt: wv=%b mean=%0d peak=%0d, required 1/100/150", w1, m, p);
        end
        // Held between windows.
        repeat (5) step(14'sd0, 1'b0);
        checks++;
        if (bus.mean_out !== 14'd100 || bus.peak_out !== 14'd150) begin
            errors++;
            $display("FAIL level_hold: mean=%0d peak=%0d, required 100/150", bus.mean_out, bus.peak_out);
        end
    endtask

    task automatic test_gaps();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(14'sd1234, 1'b0);
            pulses += int'(bus.win_valid);
            step(14'sd7, 1'b1);
            pulses += int'(bus.win_valid);
        end
        repeat (4) begin
            step(-14'sd3000, 1'b0);
            pulses += int'(bus.win_valid);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL gaps_pulses: win_valid pulses=%0d, required 1", pulses);
        end
        checks++;
        if (bus.mean_out !== 14'd7 || bus.peak_out !== 14'd7) begin
            errors++;
            $display("FAIL gaps_level: mean=%0d peak=%0d, required 7/7", bus.mean_out, bus.peak_out);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic w0, w1, w2, a0, a1;
        logic [13:0] m, p;
        state_t s;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step((i < 16) ? 14'sd300 : 14'sd600, 1'b1);
            pulses += int'(bus.win_valid);
        end
        close_window(w0, w1, w2, m, p, a0, a1, s);
        pulses += int'(w0) + int'(w1) + int'(w2);
        checks++;
        if (pulses !== 2 || m !== 14'd600 || p !== 14'd600) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d mean=%0d peak=%0d, required 2/600/600", pulses, m, p);
        end
    endtask

    task automatic test_alarm();
        int     lvl  [12] = '{3000, 3000, 500, 3000, 3000, 3000,
                              500, 500, 1500, 500, 500, 500};
        logic   exp_a[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        state_t exp_s[12] = '{ST_ARMING, ST_ARMING, ST_QUIET, ST_ARMING, ST_ARMING, ST_ALARM,
                              ST_RELEASING, ST_RELEASING, ST_ALARM, ST_RELEASING,
                              ST_RELEASING, ST_QUIET};
        logic prev_a;
        logic w0, w1, w2, a0, a1;
        logic [13:0] m, p;
        state_t s;
        pulse_clr();
        prev_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            feed(14'(lvl[i]), 14'(lvl[i]), 1'b0);
            close_window(w0, w1, w2, m, p, a0, a1, s);
            checks++;
            if (a0 !== prev_a || a1 !== exp_a[i] || s !== exp_s[i]) begin
                errors++;
                $display("FAIL alarm_win%0d: alarm at wv=%b after=%b state=%0d, required %b/%b/%0d",
                         i + 1, a0, a1, s, prev_a, exp_a[i], exp_s[i]);
            end
            prev_a = exp_a[i];
        end
    endtask

    task automatic test_reset_mid();
        logic w0, w1, w2, a0, a1;
        logic [13:0] m, p;
        state_t s;
        for (int i = 0; i < 8; i++) step(14'sd500, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mean_out !== 14'd0 || bus.peak_out !== 14'd0 || bus.alarm !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: mean=%0d peak=%0d alarm=%b, required 0/0/0",
                     bus.mean_out, bus.peak_out, bus.alarm);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        feed(14'sd20, 14'sd20, 1'b0);
        close_window(w0, w1, w2, m, p, a0, a1, s);
        checks++;
        if ({w0, w1, w2} !== 3'b010 || m !== 14'd20 || p !== 14'd20) begin
            errors++;
            $display("FAIL reset_mid: wv seq=%b%b%b mean=%0d peak=%0d, required 010/20/20",
                     w0, w1, w2, m, p);
        end
    endtask

    task automatic test_clr();
        logic w0, w1, w2, a0, a1;
        logic [13:0] m, p;
        state_t s;
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            feed(14'sd3000, 14'sd3000, 1'b0);
            close_window(w0, w1, w2, m, p, a0, a1, s);
        end
        checks++;
        if (a1 !== 1'b1 || s !== ST_ALARM) begin
            errors++;
            $display("FAIL clr_setup: alarm=%b state=%0d, required 1/%0d", a1, s, ST_ALARM);
        end
        // clr mid-alarm.
        pulse_clr();
        checks++;
        if (bus.alarm !== 1'b0 || bus.fsm_state !== ST_QUIET ||
            bus.mean_out !== 14'd3000 || bus.peak_out !== 14'd3000) begin
            errors++;
            $display("FAIL clr_alarm: alarm=%b state=%0d mean=%0d peak=%0d, required 0/QUIET/3000/3000",
                     bus.alarm, bus.fsm_state, bus.mean_out, bus.peak_out);
        end
        // clr with a valid sample mid-window: partial window and that sample dropped.
        for (int i = 0; i < 8; i++) step(14'sd3000, 1'b1);
        @(negedge clk);
        bus.clr      = 1'b1;
        bus.y_in     = 14'sd3000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        feed(14'sd40, 14'sd40, 1'b0);
        close_window(w0, w1, w2, m, p, a0, a1, s);
        checks++;
        if (w1 !== 1'b1 || m !== 14'd40 || p !== 14'd40) begin
            errors++;
            $display("FAIL clr_drop: wv=%b mean=%0d peak=%0d, required 1/40/40", w1, m, p);
        end
        // clr in the win_valid cycle beats the FSM step QUIET->ARMING.
        feed(14'sd3000, 14'sd3000, 1'b0);
        step(14'sd0, 1'b0);
        @(negedge clk);
        w1      = bus.win_valid;
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checks++;
        if (w1 !== 1'b1 || bus.fsm_state !== ST_QUIET || bus.alarm !== 1'b0 ||
            bus.mean_out !== 14'd3000) begin
            errors++;
            $display("FAIL clr_priority: wv=%b state=%0d alarm=%b mean=%0d, required 1/QUIET/0/3000",
                     w1, bus.fsm_state, bus.alarm, bus.mean_out);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_windows();
        test_gaps();
        test_back_to_back();
        test_alarm();
        test_reset_mid();
        test_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
